sevenseg_scan_ctrl: RTL and testbench

Scan sequencer and write arbiter for the multiplexed seven-segment display. It time-multiplexes the digit enables, inserts dead-time blanking between digits, and presents one hex nibble per digit slot to the segment decoder. Two requesters (CPU debug port and status logic) share the display through a round-robin valid/ready arbiter. Accepted values are committed only at frame boundaries, so the display never tears.

---
 rtl/sevenseg_scan_ctrl_if.sv | 30 +++
 rtl/sevenseg_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_ctrl_if.sv
// Requester-side handshake bundle for the seven-segment scan controller.
// Two valid/ready/data channels share the display; the controller owns the ready lines.
interface sevenseg_scan_ctrl_if #(
  parameter int NDIGITS = 3
);
  logic                   req0_valid;
  logic [4*NDIGITS-1:0]   req0_data;
  logic                   req0_ready;
  logic                   req1_valid;
  logic [4*NDIGITS-1:0]   req1_data;
  logic                   req1_ready;

  modport master (
    output req0_valid,
    output req0_data,
    input  req0_ready,
    output req1_valid,
    output req1_data,
    input  req1_ready
  );

  modport slave (
    input  req0_valid,
    input  req0_data,
    output req0_ready,
    input  req1_valid,
    input  req1_data,
    output req1_ready
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Seven-segment scan sequencer with dead-time blanking and a two-way round-robin write arbiter.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZB_EN.
module sevenseg_scan_ctrl #(
  parameter int NDIGITS      = 3,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sevenseg_scan_ctrl_if.slave  req,
  output logic [3:0]           nibble,
  output logic [NDIGITS-1:0]   digs,
  output logic                 frame_done
);

  localparam int DW    = 4 * NDIGITS;
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] SLOT_PENULT = CNT_W'(PRESCALE - 2);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NDIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [DW-1:0]       disp_reg;
  logic [DW-1:0]       shadow_reg;
  logic                shadow_valid_reg;
  logic                last_grant_reg;
  logic [3:0]          nibble_reg;
  logic [NDIGITS-1:0]  digs_reg;
  logic                frame_done_reg;

  logic                grant_sel;
  logic                ready0;
  logic                ready1;
  logic                acc0;
  logic                acc1;
  logic [NDIGITS-1:0]  onehot_next;
  logic [NDIGITS-1:0]  digs_next;
  logic [3:0]          nib_arr [NDIGITS];

  // Round-robin pick: a lone valid requester wins outright; on contention (or when
  // nobody is asking) the grant points at whoever was not served last.
  always_comb begin
    grant_sel = ~last_grant_reg;
    if (req.req0_valid && !req.req1_valid) begin
      grant_sel = 1'b0;
    end else if (req.req1_valid && !req.req0_valid) begin
      grant_sel = 1'b1;
    end
  end

  assign ready0 = !shadow_valid_reg && !grant_sel;
  assign ready1 = !shadow_valid_reg &&  grant_sel;
  assign acc0   = ready0 && req.req0_valid;
  assign acc1   = ready1 && req.req1_valid;

  assign req.req0_ready = ready0;
  assign req.req1_ready = ready1;

  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_nib
      assign nib_arr[gi] = disp_reg[4*gi +: 4];
    end
  endgenerate

  assign onehot_next = NDIGITS'(1) << idx_reg;

`ifdef SEVENSEG_LZB_EN
  // upper_zero[i]: every nibble from digit i upward is zero. Digit 0 is never blanked.
  logic [NDIGITS-1:0] upper_zero;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_lzb
      assign upper_zero[gi] = (disp_reg[DW-1:4*gi] == '0);
    end
  endgenerate
  assign digs_next = onehot_next & ~(upper_zero & ~NDIGITS'(1));
`else
  assign digs_next = onehot_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_BLANK;
      cnt_reg          <= '0;
      idx_reg          <= '0;
      disp_reg         <= '0;
      shadow_reg       <= '0;
      shadow_valid_reg <= 1'b0;
      last_grant_reg   <= 1'b1;
      nibble_reg       <= 4'h0;
      digs_reg         <= '0;
      frame_done_reg   <= 1'b0;
    end else begin
      // Registered one cycle early so the pulse lines up with the slot's final cycle.
      frame_done_reg <= (cnt_reg == SLOT_PENULT) && (idx_reg == IDX_LAST);

      case (state_reg)
        ST_BLANK: begin
          cnt_reg <= cnt_reg + CNT_ONE;
          if (cnt_reg == BLANK_LAST) begin
            state_reg  <= ST_DRIVE;
            digs_reg   <= digs_next;
            nibble_reg <= nib_arr[idx_reg];
          end
        end
        ST_DRIVE: begin
          if (cnt_reg == SLOT_LAST) begin
            cnt_reg   <= '0;
            idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_ONE;
            digs_reg  <= '0;
            state_reg <= ST_BLANK;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_reg <= ST_BLANK;
          cnt_reg   <= '0;
          digs_reg  <= '0;
        end
      endcase

      // Accept requires an empty shadow, commit requires a full one: never both at once.
      if (acc0) begin
        shadow_reg       <= req.req0_data;
        shadow_valid_reg <= 1'b1;
        last_grant_reg   <= 1'b0;
      end else if (acc1) begin
        shadow_reg       <= req.req1_data;
        shadow_valid_reg <= 1'b1;
        last_grant_reg   <= 1'b1;
      end else if (frame_done_reg && shadow_valid_reg) begin
        disp_reg         <= shadow_reg;
        shadow_valid_reg <= 1'b0;
      end
    end
  end

  assign nibble     = nibble_reg;
  assign digs       = digs_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl (NDIGITS=3, PRESCALE=8, BLANK_CYCLES=2).
module tb_sevenseg_scan_ctrl;

  localparam int ND = 3;
  localparam int PS = 8;
  localparam int BC = 2;
`ifdef SEVENSEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    nibble;
  logic [ND-1:0] digs;
  logic          frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  sevenseg_scan_ctrl_if #(.NDIGITS(ND)) bus ();

  sevenseg_scan_ctrl #(
    .NDIGITS(ND),
    .PRESCALE(PS),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(bus),
    .nibble(nibble),
    .digs(digs),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  // cycle k spans posedge k .. posedge k+1 after reset release; sample at posedge+1
  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic restart();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_data  = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    #1;
  endtask

  task automatic send0(input logic [11:0] d, input string tag);
    bus.req0_valid = 1'b1;
    bus.req0_data  = d;
    #1;
    $display("cyc=%0d req0 data=%h ready0=%b ready1=%b", cyc, d, bus.req0_ready, bus.req1_ready);
    chk(tag, {31'd0, bus.req0_ready}, 32'd1);
  endtask

  initial begin
    // 1: idle scan timing
    restart();
    chk("t1_rst_digs", {29'd0, digs}, 32'd0);
    chk("t1_rst_nib", {28'd0, nibble}, 32'd0);
    chk("t1_rst_fd", {31'd0, frame_done}, 32'd0);
    goto(1);  chk("t1_c1_digs", {29'd0, digs}, 32'd0);
    goto(2);  chk("t1_c2_digs", {29'd0, digs}, 32'd1);
    goto(7);  chk("t1_c7_digs", {29'd0, digs}, 32'd1);
    goto(8);  chk("t1_c8_digs", {29'd0, digs}, 32'd0);
    goto(10); chk("t1_c10_digs", {29'd0, digs}, 32'd2);
    goto(18); chk("t1_c18_digs", {29'd0, digs}, 32'd4);
    chk("t1_c18_nib", {28'd0, nibble}, 32'd0);
    goto(22); chk("t1_c22_fd", {31'd0, frame_done}, 32'd0);
    goto(23); chk("t1_c23_fd", {31'd0, frame_done}, 32'd1);
    goto(24); chk("t1_c24_fd", {31'd0, frame_done}, 32'd0);
    chk("t1_c24_digs", {29'd0, digs}, 32'd0);
    goto(46); chk("t1_c46_fd", {31'd0, frame_done}, 32'd0);
    goto(47); chk("t1_c47_fd", {31'd0, frame_done}, 32'd1);

    // 2: single write, committed at the frame boundary
    restart();
    goto(5);
    send0(12'h3A5, "t2_ready0");
    chk("t2_ready1", {31'd0, bus.req1_ready}, 32'd0);
    goto(6);
    bus.req0_valid = 1'b0;
    chk("t2_shadow_full", {31'd0, bus.req0_ready}, 32'd0);
    goto(18); chk("t2_c18_nib", {28'd0, nibble}, 32'd0);
    goto(26); chk("t2_c26_digs", {29'd0, digs}, 32'd1);
    chk("t2_c26_nib", {28'd0, nibble}, 32'h5);
    goto(34); chk("t2_c34_digs", {29'd0, digs}, 32'd2);
    chk("t2_c34_nib", {28'd0, nibble}, 32'hA);
    goto(42); chk("t2_c42_digs", {29'd0, digs}, 32'd4);
    chk("t2_c42_nib", {28'd0, nibble}, 32'h3);

    // 3: contention, req0 wins first, req1 waits for the commit
    restart();
    goto(3);
    bus.req1_valid = 1'b1;
    bus.req1_data  = 12'h222;
    send0(12'h111, "t3_ready0");
    chk("t3_c3_ready1", {31'd0, bus.req1_ready}, 32'd0);
    goto(4);
    bus.req0_valid = 1'b0;
    #1;
    chk("t3_c4_ready1", {31'd0, bus.req1_ready}, 32'd0);
    goto(23); chk("t3_c23_ready1", {31'd0, bus.req1_ready}, 32'd0);
    goto(24); chk("t3_c24_ready1", {31'd0, bus.req1_ready}, 32'd1);
    $display("cyc=%0d req1 data=%h ready1=%b", cyc, bus.req1_data, bus.req1_ready);
    goto(25);
    bus.req1_valid = 1'b0;
    goto(26); chk("t3_c26_nib", {28'd0, nibble}, 32'h1);
    goto(42); chk("t3_c42_nib", {28'd0, nibble}, 32'h1);
    goto(50); chk("t3_c50_nib", {28'd0, nibble}, 32'h2);
    goto(58); chk("t3_c58_nib", {28'd0, nibble}, 32'h2);

    // 4: accept on the frame_done cycle slips one frame
    restart();
    goto(23);
    chk("t4_c23_fd", {31'd0, frame_done}, 32'd1);
    send0(12'h777, "t4_ready0");
    goto(24);
    bus.req0_valid = 1'b0;
    goto(26); chk("t4_c26_nib", {28'd0, nibble}, 32'h0);
    goto(42); chk("t4_c42_nib", {28'd0, nibble}, 32'h0);
    goto(50); chk("t4_c50_nib", {28'd0, nibble}, 32'h7);

    // 5: asynchronous reset mid-DRIVE with a pending word
    restart();
    goto(2);
    send0(12'h3A5, "t5_ready0_a");
    goto(3);
    bus.req0_valid = 1'b0;
    goto(26); chk("t5_c26_nib", {28'd0, nibble}, 32'h5);
    goto(28);
    send0(12'h999, "t5_ready0_b");
    goto(29);
    bus.req0_valid = 1'b0;
    chk("t5_c29_digs", {29'd0, digs}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_digs", {29'd0, digs}, 32'd0);
    chk("t5_async_nib", {28'd0, nibble}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    #1;
    chk("t5_c0_digs", {29'd0, digs}, 32'd0);
    goto(2);  chk("t5_c2_digs", {29'd0, digs}, 32'd1);
    chk("t5_c2_nib", {28'd0, nibble}, 32'h0);
    goto(3);
    bus.req0_valid = 1'b1;
    #1;
    chk("t5_shadow_empty", {31'd0, bus.req0_ready}, 32'd1);
    bus.req0_valid = 1'b0;
    goto(26); chk("t5_lost_nib0", {28'd0, nibble}, 32'h0);
    goto(34); chk("t5_lost_nib1", {28'd0, nibble}, 32'h0);

    // 6: leading-zero blanking (expectations follow the build option)
    restart();
    goto(2);
    send0(12'h005, "t6_ready0_a");
    goto(3);
    bus.req0_valid = 1'b0;
    goto(26); chk("t6_c26_digs", {29'd0, digs}, 32'd1);
    chk("t6_c26_nib", {28'd0, nibble}, 32'h5);
    goto(34); chk("t6_c34_digs", {29'd0, digs}, LZB ? 32'd0 : 32'd2);
    goto(42); chk("t6_c42_digs", {29'd0, digs}, LZB ? 32'd0 : 32'd4);
    goto(47); chk("t6_c47_fd", {31'd0, frame_done}, 32'd1);
    goto(48);
    send0(12'h050, "t6_ready0_b");
    goto(49);
    bus.req0_valid = 1'b0;
    goto(74); chk("t6_c74_digs", {29'd0, digs}, 32'd1);
    chk("t6_c74_nib", {28'd0, nibble}, 32'h0);
    goto(82); chk("t6_c82_digs", {29'd0, digs}, 32'd2);
    chk("t6_c82_nib", {28'd0, nibble}, 32'h5);
    goto(90); chk("t6_c90_digs", {29'd0, digs}, LZB ? 32'd0 : 32'd4);
    goto(94); chk("t6_c94_fd", {31'd0, frame_done}, 32'd0);
    goto(95); chk("t6_c95_fd", {31'd0, frame_done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
